hazard_ctrl: RTL
================

# hazard_ctrl

Pipeline hazard controller for the five-stage MIPS core. It tracks the destination register and result-ready countdown (Tnew) of the instructions in E, M and W, and compares them with the operand demand (Tuse) of the instruction in D. From this it drives the select lines of the D-stage and E-stage forwarding multiplexers and the global stall. It also owns the multiply/divide busy counter and holds back any HI/LO-unit instruction while that unit is occupied.

## Interface
- MULT_CYCLES, 5, busy cycles after a mult/multu enters E
- DIV_CYCLES, 10, busy cycles after a div/divu enters E

- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- D_rs, D_rt  in  5 each  source register numbers of the D instruction
- D_rs_tuse, D_rt_tuse  in  2 each  0 = needed in D, 1 = needed in E, 2 = needed in M, 3 = unused
- D_wa  in  5  destination register; 0 means no write
- D_tnew  in  2  Tnew the instruction will have on entering E (0 = lui/jal class, 1 = ALU, 2 = load)
- D_md_start  in  1  D instruction is mult/multu/div/divu
- D_md_div  in  1  with D_md_start: divide (selects DIV_CYCLES)
- D_md_use  in  1  D instruction uses the HI/LO unit (mult*, div*, mfhi, mflo, mthi, mtlo)
- stall  out  1  freeze PC and F/D; insert a bubble into D/E
- fwd_D_rs_sel, fwd_D_rt_sel  out  2 each  D-mux select: 0 = RD1/RD2, 1 = E_Forward, 2 = M_Forward
- fwd_E_rs_sel, fwd_E_rt_sel  out  2 each  E-mux select: 0 = pipelined value, 1 = M result, 2 = W result
- md_busy  out  1  HI/LO unit counter nonzero

## Operation
- Internal stage records:
  - E: wa, tnew, rs, rt, md_start, md_div.
  - M: wa, tnew.
  - W: wa.
- Clock update when stall = 0:
  - E record ← D inputs.
  - M.wa ← E.wa; M.tnew ← max(E.tnew − 1, 0).
  - W.wa ← M.wa.
- Clock update when stall = 1:
  - E record cleared to a bubble (all fields 0).
  - M and W advance as above; W always holds Tnew = 0.
- Match rule: stage X matches source s when X.wa == s and s != 0 and s's tuse != 3.
- stall is asserted when any of the following hold for rs or rt:
  - the E stage matches and E.tnew > tuse;
  - the M stage matches and M.tnew > tuse;
  - D_md_use and (md_busy or E.md_start).
- D select (per source):
  - 1 if the E stage matches and E.tnew == 0;
  - else 2 if the E stage does not match, the M stage matches and M.tnew == 0;
  - else 0.
- The nearest stage always wins. If E matches with nonzero Tnew, the D select is 0 and the stall or the later E-stage forward covers the hazard.
- E select (per E.rs/E.rt; register 0 never forwards):
  - 1 if M.wa matches and M.tnew == 0;
  - else 2 if W.wa matches;
  - else 0.
- HI/LO counter (width 4 minimum):
  - When E.md_start = 1 it loads on that edge, to DIV_CYCLES if E.md_div else MULT_CYCLES.
  - Otherwise it decrements by 1 while nonzero.
  - md_busy = (count != 0).
  - A new start cannot arrive while busy, because starts also assert D_md_use and therefore stall.
- Outputs are combinational from the stage records, the counter and the D inputs. No output is registered.

## Timing
- Reset (synchronous):
  - all records, W.wa and the counter are cleared to 0;
  - while reset is high and on the first cycle after it: stall = 0, every select = 0, md_busy = 0.
- Stall takes effect in the same cycle as the D-stage hazard and lasts exactly as long as the inequality holds.
- Load followed by a dependent ALU instruction: 1 stall cycle, then fwd_E_*_sel = 2.
- Load followed by a dependent branch (tuse 0): 2 stall cycles, then the value comes through RD1 via the register-file internal bypass.
- ALU result followed by a branch: 1 stall cycle (E.tnew = 1 > 0), then fwd_D_*_sel = 2.
- mult entering E at edge k: md_busy is high from cycle k+1 through k+MULT_CYCLES. A waiting mflo is released in the cycle md_busy falls.
- Reset asserted mid-stall or mid-count: all state clears on that edge with no residual stall.
- Writes to $0 never stall and never forward.

## Test plan
- lw $1 then add $2,$1,$3 → stall = 1 for exactly 1 cycle; next cycle fwd_E_rs_sel = 2; fwd_D_* = 0 throughout.
- addu $1 then beq $1,$0 → 1 stall cycle, then fwd_D_rs_sel = 2 for one cycle.
- jal (D_wa = 31, D_tnew = 0) then jr $31 → no stall; fwd_D_rs_sel = 1 the cycle after jal enters E.
- addu $0,$4,$5 then beq $0,$0 → stall = 0, all selects 0.
- mult then mflo immediately → stall held 1 + MULT_CYCLES = 6 cycles; md_busy high for 5; mflo enters E on cycle 7.
- div enters E, reset pulsed 3 cycles later → md_busy = 0 and stall = 0 on the next cycle; a following mfhi proceeds without stalling.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: D-stage operand demand in, stall/forward selects and HI/LO busy out
//   master: drives the D-stage fields, observes stall/forward/busy
//   slave : hazard_ctrl side, consumes the D-stage fields, drives stall/forward/busy
interface hazard_ctrl_if;
    logic [4:0] D_rs;
    logic [4:0] D_rt;
    logic [1:0] D_rs_tuse;
    logic [1:0] D_rt_tuse;
    logic [4:0] D_wa;
    logic [1:0] D_tnew;
    logic       D_md_start;
    logic       D_md_div;
    logic       D_md_use;
    logic       stall;
    logic [1:0] fwd_D_rs_sel;
    logic [1:0] fwd_D_rt_sel;
    logic [1:0] fwd_E_rs_sel;
    logic [1:0] fwd_E_rt_sel;
    logic       md_busy;
    modport master (
        output D_rs, D_rt, D_rs_tuse, D_rt_tuse, D_wa, D_tnew, D_md_start, D_md_div, D_md_use,
        input  stall, fwd_D_rs_sel, fwd_D_rt_sel, fwd_E_rs_sel, fwd_E_rt_sel, md_busy
    );
    modport slave (
        input  D_rs, D_rt, D_rs_tuse, D_rt_tuse, D_wa, D_tnew, D_md_start, D_md_div, D_md_use,
        output stall, fwd_D_rs_sel, fwd_D_rt_sel, fwd_E_rs_sel, fwd_E_rt_sel, md_busy
    );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: Tuse/Tnew stall and forwarding control plus HI/LO busy counter for a 5-stage MIPS core
//   clk   : rising-edge clock
//   reset : synchronous active-high reset
//   bus   : hazard_ctrl_if.slave (D-stage demand in; stall, D/E forward selects, md_busy out)
module hazard_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic          clk,
    input  logic          reset,
    hazard_ctrl_if.slave  bus
);
    localparam int MAXC = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1) < 4 ? 4 : $clog2(MAXC + 1);

    logic [4:0]    e_wa_q, e_wa_d, e_rs_q, e_rs_d, e_rt_q, e_rt_d, m_wa_q, m_wa_d, w_wa_q, w_wa_d;
    logic [1:0]    e_tnew_q, e_tnew_d, m_tnew_q, m_tnew_d;
    logic          e_md_start_q, e_md_start_d, e_md_div_q, e_md_div_d;
    logic [CW-1:0] md_cnt_q, md_cnt_d;
    logic          e_rs_hit, e_rt_hit, m_rs_hit, m_rt_hit, stall_raw;

    always_comb begin
        e_rs_hit  = bus.D_rs != 5'd0 && bus.D_rs_tuse != 2'd3 && e_wa_q == bus.D_rs;
        e_rt_hit  = bus.D_rt != 5'd0 && bus.D_rt_tuse != 2'd3 && e_wa_q == bus.D_rt;
        m_rs_hit  = bus.D_rs != 5'd0 && bus.D_rs_tuse != 2'd3 && m_wa_q == bus.D_rs;
        m_rt_hit  = bus.D_rt != 5'd0 && bus.D_rt_tuse != 2'd3 && m_wa_q == bus.D_rt;
        stall_raw = (e_rs_hit && e_tnew_q > bus.D_rs_tuse) || (m_rs_hit && m_tnew_q > bus.D_rs_tuse) ||
                    (e_rt_hit && e_tnew_q > bus.D_rt_tuse) || (m_rt_hit && m_tnew_q > bus.D_rt_tuse) ||
                    (bus.D_md_use && (md_cnt_q != '0 || e_md_start_q));
        // outputs are forced quiet while reset is held, even before state has been cleared
        bus.stall   = !reset && stall_raw;
        bus.md_busy = !reset && md_cnt_q != '0;
        // nearest stage wins: an E match with nonzero Tnew blocks an older M forward
        bus.fwd_D_rs_sel = reset ? 2'd0 : (e_rs_hit && e_tnew_q == 2'd0) ? 2'd1 :
                           (!e_rs_hit && m_rs_hit && m_tnew_q == 2'd0) ? 2'd2 : 2'd0;
        bus.fwd_D_rt_sel = reset ? 2'd0 : (e_rt_hit && e_tnew_q == 2'd0) ? 2'd1 :
                           (!e_rt_hit && m_rt_hit && m_tnew_q == 2'd0) ? 2'd2 : 2'd0;
        bus.fwd_E_rs_sel = (reset || e_rs_q == 5'd0) ? 2'd0 : (m_wa_q == e_rs_q && m_tnew_q == 2'd0) ? 2'd1 :
                           (w_wa_q == e_rs_q) ? 2'd2 : 2'd0;
        bus.fwd_E_rt_sel = (reset || e_rt_q == 5'd0) ? 2'd0 : (m_wa_q == e_rt_q && m_tnew_q == 2'd0) ? 2'd1 :
                           (w_wa_q == e_rt_q) ? 2'd2 : 2'd0;
        // a stall turns the D/E register into a bubble
        e_wa_d       = stall_raw ? 5'd0 : bus.D_wa;
        e_rs_d       = stall_raw ? 5'd0 : bus.D_rs;
        e_rt_d       = stall_raw ? 5'd0 : bus.D_rt;
        e_tnew_d     = stall_raw ? 2'd0 : bus.D_tnew;
        e_md_start_d = !stall_raw && bus.D_md_start;
        e_md_div_d   = !stall_raw && bus.D_md_div;
        m_wa_d       = e_wa_q;
        m_tnew_d     = e_tnew_q == 2'd0 ? 2'd0 : e_tnew_q - 2'd1;
        w_wa_d       = m_wa_q;
        md_cnt_d     = e_md_start_q ? (e_md_div_q ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES)) :
                       md_cnt_q != '0 ? md_cnt_q - CW'(1) : md_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            e_wa_q       <= '0;
            e_rs_q       <= '0;
            e_rt_q       <= '0;
            e_tnew_q     <= '0;
            e_md_start_q <= 1'b0;
            e_md_div_q   <= 1'b0;
            m_wa_q       <= '0;
            m_tnew_q     <= '0;
            w_wa_q       <= '0;
            md_cnt_q     <= '0;
        end else begin
            e_wa_q       <= e_wa_d;
            e_rs_q       <= e_rs_d;
            e_rt_q       <= e_rt_d;
            e_tnew_q     <= e_tnew_d;
            e_md_start_q <= e_md_start_d;
            e_md_div_q   <= e_md_div_d;
            m_wa_q       <= m_wa_d;
            m_tnew_q     <= m_tnew_d;
            w_wa_q       <= w_wa_d;
            md_cnt_q     <= md_cnt_d;
        end
    end
endmodule
